rgb_fade_sequencer: RTL and testbench

- Keyframe scheduler for the three-channel RGB PWM datapath. Holds a small table of RGB colour keyframes.
- Ramps three 16-bit duty values toward each keyframe at a programmable rate, holds, then advances; optionally loops.
- Outputs feed the PWMConData inputs of the R/G/B PWM instances, replacing the free-running triangle generator in the LED controller.

---
 rtl/rgb_fade_sequencer_if.sv | 40 ++++
 rtl/rgb_fade_sequencer.sv | 172 +++++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_fade_sequencer_if.sv
// Control/status bundle for rgb_fade_sequencer.
// Strobe semantics: cfg_we, start and stop are single-cycle strobes with no
// back-pressure. Each one is acted on at the CLK edge where it is high. The
// sequencer has no ready signal: a write is always accepted, a start while
// busy is dropped, and stop always wins.
interface rgb_fade_sequencer_if #(
    parameter int DUTY_W = 16,
    parameter int IDX_W  = 3,
    parameter int DIV_W  = 24
);
    logic                  cfg_we;
    logic [IDX_W-1:0]      cfg_addr;
    logic [3*DUTY_W-1:0]   cfg_data;
    logic [DIV_W-1:0]      step_div;
    logic [DUTY_W-1:0]     step_size;
    logic [15:0]           hold_steps;
    logic [IDX_W-1:0]      last_idx;
    logic                  loop_en;
    logic                  start;
    logic                  stop;
    logic [DUTY_W-1:0]     duty_r;
    logic [DUTY_W-1:0]     duty_g;
    logic [DUTY_W-1:0]     duty_b;
    logic                  busy;
    logic [IDX_W-1:0]      frame_idx;
    logic                  frame_done;
    logic [1:0]            dbg_state;

    modport master (
        output cfg_we, cfg_addr, cfg_data, step_div, step_size, hold_steps,
               last_idx, loop_en, start, stop,
        input  duty_r, duty_g, duty_b, busy, frame_idx, frame_done, dbg_state
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, step_div, step_size, hold_steps,
               last_idx, loop_en, start, stop,
        output duty_r, duty_g, duty_b, busy, frame_idx, frame_done, dbg_state
    );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// Keyframe scheduler for the RGB PWM datapath: ramps three duty values toward
// table keyframes at a programmable rate, holds each one, then advances
// (optionally looping). dbg_state exposes the FSM state (0 IDLE, 1 LOAD,
// 2 FADE, 3 HOLD).
module rgb_fade_sequencer #(
    parameter int DUTY_W = 16,
    parameter int IDX_W  = 3,
    parameter int DIV_W  = 24
) (
    input  logic                   CLK,
    input  logic                   nRST,
    rgb_fade_sequencer_if.slave    ctl
);
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FADE = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3*DUTY_W-1:0]   r_table [DEPTH];
    logic [DUTY_W-1:0]     r_tgt_r, r_tgt_g, r_tgt_b;
    logic [DUTY_W-1:0]     r_duty_r, r_duty_g, r_duty_b;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [15:0]           r_hold_cnt;
    logic [IDX_W-1:0]      r_frame_idx;
    logic                  r_frame_done;

    logic [DIV_W-1:0]      w_div_term;
    logic [DUTY_W-1:0]     w_step;
    logic                  w_tick;
    logic                  w_all_eq;
    logic                  w_hold_done;
    logic                  w_start_ok;

    // Move cur toward tgt by at most step; never overshoots, never wraps.
    function automatic logic [DUTY_W-1:0] f_step(input logic [DUTY_W-1:0] cur,
                                                 input logic [DUTY_W-1:0] tgt,
                                                 input logic [DUTY_W-1:0] step);
        logic [DUTY_W-1:0] diff;
        if (tgt > cur) begin
            diff   = tgt - cur;
            f_step = cur + ((diff < step) ? diff : step);
        end else begin
            diff   = cur - tgt;
            f_step = cur - ((diff < step) ? diff : step);
        end
    endfunction

    // Zero divider/step values behave as 1 so the sequencer always makes progress.
    assign w_div_term = (ctl.step_div == '0) ? '0 : ctl.step_div - DIV_W'(1);
    assign w_step     = (ctl.step_size == '0) ? DUTY_W'(1) : ctl.step_size;
    assign w_tick     = ((r_state == S_FADE) || (r_state == S_HOLD)) && (r_div_cnt == w_div_term);
    assign w_all_eq   = (r_duty_r == r_tgt_r) && (r_duty_g == r_tgt_g) && (r_duty_b == r_tgt_b);
    assign w_start_ok = (r_state == S_IDLE) && ctl.start && !ctl.stop;

    // Next-state logic; stop overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        w_hold_done  = 1'b0;
        case (r_state)
            S_IDLE: if (ctl.start) w_next_state = S_LOAD;
            S_LOAD: w_next_state = S_FADE;
            S_FADE: if (w_all_eq) w_next_state = S_HOLD;
            S_HOLD: begin
                if (w_tick && (r_hold_cnt == 16'd0)) begin
                    w_hold_done = 1'b1;
                    if ((r_frame_idx != ctl.last_idx) || ctl.loop_en) w_next_state = S_LOAD;
                    else                                               w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (ctl.stop) begin
            w_next_state = S_IDLE;
            w_hold_done  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Keyframe table: writes accepted in any state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
        end else if (ctl.cfg_we) begin
            r_table[ctl.cfg_addr] <= ctl.cfg_data;
        end
    end

    // Step-rate divider: cleared on FADE entry, free-runs through FADE and HOLD.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_div_cnt <= '0;
        end else if ((w_next_state == S_FADE) && (r_state != S_FADE)) begin
            r_div_cnt <= '0;
        end else if ((r_state == S_FADE) || (r_state == S_HOLD)) begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
        end else begin
            r_div_cnt <= '0;
        end
    end

    // Target latch, only in LOAD, so table edits apply at the next load.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_tgt_r <= '0;
            r_tgt_g <= '0;
            r_tgt_b <= '0;
        end else if (r_state == S_LOAD) begin
            {r_tgt_r, r_tgt_g, r_tgt_b} <= r_table[r_frame_idx];
        end
    end

    // Duty ramp: one bounded step per tick while fading; frozen on stop.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_duty_r <= '0;
            r_duty_g <= '0;
            r_duty_b <= '0;
        end else if ((r_state == S_FADE) && w_tick && !ctl.stop) begin
            r_duty_r <= f_step(r_duty_r, r_tgt_r, w_step);
            r_duty_g <= f_step(r_duty_g, r_tgt_g, w_step);
            r_duty_b <= f_step(r_duty_b, r_tgt_b, w_step);
        end
    end

    // Hold counter: loaded when the keyframe is reached, decremented per tick.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hold_cnt <= '0;
        end else if ((r_state == S_FADE) && w_all_eq) begin
            r_hold_cnt <= ctl.hold_steps;
        end else if ((r_state == S_HOLD) && w_tick && (r_hold_cnt != 16'd0) && !ctl.stop) begin
            r_hold_cnt <= r_hold_cnt - 16'd1;
        end
    end

    // Frame index: reset on start, advanced or wrapped when a hold completes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_frame_idx <= '0;
        end else if (w_start_ok) begin
            r_frame_idx <= '0;
        end else if (w_hold_done) begin
            if (r_frame_idx != ctl.last_idx) r_frame_idx <= r_frame_idx + IDX_W'(1);
            else if (ctl.loop_en)            r_frame_idx <= '0;
        end
    end

    // Registered one-cycle completion pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_frame_done <= 1'b0;
        else       r_frame_done <= w_hold_done;
    end

    assign ctl.duty_r     = r_duty_r;
    assign ctl.duty_g     = r_duty_g;
    assign ctl.duty_b     = r_duty_b;
    assign ctl.busy       = (r_state != S_IDLE);
    assign ctl.frame_idx  = r_frame_idx;
    assign ctl.frame_done = r_frame_done;
    assign ctl.dbg_state  = r_state;
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer: each task drives one scenario and
// checks outputs against hand-computed values, sampled 1 ns after CLK rises.
module tb_rgb_fade_sequencer;
    logic CLK;
    logic nRST;
    int   n_vec;
    int   n_err;

    rgb_fade_sequencer_if #(.DUTY_W(16), .IDX_W(3), .DIV_W(24)) bus ();

    rgb_fade_sequencer #(.DUTY_W(16), .IDX_W(3), .DIV_W(24)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .ctl  (bus.slave)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic write_slot(input int a, input logic [47:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'(a);
        bus.cfg_data = d;
        step(1);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic config_run(input int div, input int sz, input int hold,
                              input int last, input logic lp);
        bus.step_div   = 24'(div);
        bus.step_size  = 16'(sz);
        bus.hold_steps = 16'(hold);
        bus.last_idx   = 3'(last);
        bus.loop_en    = lp;
    endtask

    // Run until busy drops; counts frame_done pulses; bounded.
    task automatic wait_idle(input int max_cyc, output int pulses);
        int c;
        pulses = 0;
        c = 0;
        while (bus.busy && c < max_cyc) begin
            step(1);
            c++;
            if (bus.frame_done) pulses++;
        end
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle_timeout: busy=%0b after %0d cycles, expected 0", bus.busy, c);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        step(2);
        n_vec++; if (bus.duty_r !== 16'd0 || bus.duty_g !== 16'd0 || bus.duty_b !== 16'd0) begin
            n_err++; $display("FAIL reset_duty: got %h/%h/%h expected 0/0/0", bus.duty_r, bus.duty_g, bus.duty_b); end
        n_vec++; if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.frame_idx !== 3'd0) begin
            n_err++; $display("FAIL reset_ctl: busy=%b done=%b idx=%0d expected 0 0 0", bus.busy, bus.frame_done, bus.frame_idx); end
        nRST = 1'b1;
        step(1);
        n_vec++; if (bus.dbg_state !== 2'd0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL post_reset_idle: state=%0d busy=%b expected 0 0", bus.dbg_state, bus.busy); end
    endtask

    task automatic test_basic_fade();
        int p;
        write_slot(0, {16'd1000, 16'd0, 16'd500});
        config_run(4, 250, 0, 0, 1'b0);
        pulse_start();
        n_vec++; if (bus.dbg_state !== 2'd1 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL start_to_load: state=%0d busy=%b expected 1 1", bus.dbg_state, bus.busy); end
        step(1);
        n_vec++; if (bus.dbg_state !== 2'd2) begin
            n_err++; $display("FAIL load_to_fade: state=%0d expected 2", bus.dbg_state); end
        step(3);
        n_vec++; if (bus.duty_r !== 16'd0) begin
            n_err++; $display("FAIL first_tick_latency: duty_r=%0d expected 0", bus.duty_r); end
        step(1);
        n_vec++; if (bus.duty_r !== 16'd250 || bus.duty_b !== 16'd250) begin
            n_err++; $display("FAIL tick1: r=%0d b=%0d expected 250 250", bus.duty_r, bus.duty_b); end
        step(4);
        n_vec++; if (bus.duty_r !== 16'd500 || bus.duty_b !== 16'd500) begin
            n_err++; $display("FAIL tick2: r=%0d b=%0d expected 500 500", bus.duty_r, bus.duty_b); end
        step(8);
        n_vec++; if (bus.duty_r !== 16'd1000 || bus.duty_g !== 16'd0 || bus.duty_b !== 16'd500) begin
            n_err++; $display("FAIL tick4: %0d/%0d/%0d expected 1000/0/500", bus.duty_r, bus.duty_g, bus.duty_b); end
        step(3);
        n_vec++; if (bus.frame_done !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL hold_wait: done=%b busy=%b expected 0 1", bus.frame_done, bus.busy); end
        step(1);
        n_vec++; if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL frame_done_pulse: done=%b busy=%b expected 1 0", bus.frame_done, bus.busy); end
        step(1);
        n_vec++; if (bus.frame_done !== 1'b0) begin
            n_err++; $display("FAIL frame_done_width: done=%b expected 0", bus.frame_done); end
        step(3);
        n_vec++; if (bus.duty_r !== 16'd1000 || bus.duty_g !== 16'd0 || bus.duty_b !== 16'd500 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL idle_retain: %0d/%0d/%0d busy=%b expected 1000/0/500 0", bus.duty_r, bus.duty_g, bus.duty_b, bus.busy); end
        p = 0;
    endtask

    task automatic test_clamp();
        int p;
        write_slot(0, {16'h0000, 16'hFFFF, 16'h0000});
        config_run(4, 16'h7000, 0, 0, 1'b0);
        pulse_start();
        step(1);
        step(4);
        n_vec++; if (bus.duty_r !== 16'h0000 || bus.duty_g !== 16'h7000 || bus.duty_b !== 16'h0000) begin
            n_err++; $display("FAIL clamp_tick1: %h/%h/%h expected 0000/7000/0000", bus.duty_r, bus.duty_g, bus.duty_b); end
        step(4);
        n_vec++; if (bus.duty_g !== 16'hE000 || bus.duty_r !== 16'h0000) begin
            n_err++; $display("FAIL clamp_tick2: r=%h g=%h expected 0000 E000", bus.duty_r, bus.duty_g); end
        step(4);
        n_vec++; if (bus.duty_g !== 16'hFFFF) begin
            n_err++; $display("FAIL clamp_top: g=%h expected FFFF", bus.duty_g); end
        wait_idle(100, p);
        n_vec++; if (p !== 1 || bus.duty_g !== 16'hFFFF) begin
            n_err++; $display("FAIL clamp_done: pulses=%0d g=%h expected 1 FFFF", p, bus.duty_g); end
    endtask

    task automatic test_loop_live_edit();
        int loads[$];
        int done_cyc[$];
        logic [47:0] done_duty[$];
        int exp_loads[5];
        int cyc;
        int busy_drop;
        logic edited;
        logic edit_pending;
        exp_loads = '{0, 1, 2, 0, 1};
        write_slot(0, {16'h0100, 16'h0000, 16'h0000});
        write_slot(1, {16'h0100, 16'h0100, 16'h0000});
        write_slot(2, {16'h0000, 16'h0000, 16'h0100});
        config_run(2, 16'hFFFF, 3, 2, 1'b1);
        pulse_start();
        loads.push_back(int'(bus.frame_idx));
        cyc = 0;
        busy_drop = 0;
        edited = 1'b0;
        edit_pending = 1'b0;
        while (done_cyc.size() < 5 && cyc < 300) begin
            step(1);
            cyc++;
            if (edit_pending) begin
                bus.cfg_we = 1'b0;
                edit_pending = 1'b0;
            end
            if (bus.busy !== 1'b1) busy_drop++;
            if (bus.dbg_state == 2'd1) loads.push_back(int'(bus.frame_idx));
            if (bus.frame_done) begin
                done_cyc.push_back(cyc);
                done_duty.push_back({bus.duty_r, bus.duty_g, bus.duty_b});
            end
            if (!edited && bus.dbg_state == 2'd3 && bus.frame_idx == 3'd1) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = 3'd1;
                bus.cfg_data = {16'h0200, 16'h0200, 16'h0000};
                edited = 1'b1;
                edit_pending = 1'b1;
            end
        end
        bus.cfg_we = 1'b0;
        n_vec++; if (done_cyc.size() != 5 || loads.size() < 5) begin
            n_err++; $display("FAIL loop_progress: pulses=%0d loads=%0d expected 5 >=5", done_cyc.size(), loads.size()); end
        for (int k = 0; k < 5; k++) begin
            if (k < loads.size()) begin
                n_vec++; if (loads[k] != exp_loads[k]) begin
                    n_err++; $display("FAIL loop_idx[%0d]: got %0d expected %0d", k, loads[k], exp_loads[k]); end
            end
        end
        for (int k = 1; k < done_cyc.size(); k++) begin
            n_vec++; if (done_cyc[k] - done_cyc[k-1] != 11) begin
                n_err++; $display("FAIL loop_spacing[%0d]: got %0d cycles expected 11", k, done_cyc[k] - done_cyc[k-1]); end
        end
        if (done_duty.size() == 5) begin
            n_vec++; if (done_duty[1] !== {16'h0100, 16'h0100, 16'h0000}) begin
                n_err++; $display("FAIL edit_not_immediate: got %h expected 010001000000", done_duty[1]); end
            n_vec++; if (done_duty[4] !== {16'h0200, 16'h0200, 16'h0000}) begin
                n_err++; $display("FAIL edit_next_pass: got %h expected 020002000000", done_duty[4]); end
        end
        n_vec++; if (busy_drop != 0) begin
            n_err++; $display("FAIL loop_busy: busy low %0d cycles expected 0", busy_drop); end
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        n_vec++; if (bus.busy !== 1'b0 || bus.dbg_state !== 2'd0) begin
            n_err++; $display("FAIL loop_stop: busy=%b state=%0d expected 0 0", bus.busy, bus.dbg_state); end
    endtask

    task automatic test_stop_mid_fade();
        int p;
        int seen;
        write_slot(0, 48'd0);
        config_run(2, 16'hFFFF, 0, 0, 1'b0);
        pulse_start();
        wait_idle(100, p);
        write_slot(0, {16'd1000, 16'd0, 16'd0});
        config_run(4, 250, 0, 0, 1'b0);
        pulse_start();
        step(1);
        step(8);
        n_vec++; if (bus.duty_r !== 16'd500) begin
            n_err++; $display("FAIL stop_pre: duty_r=%0d expected 500", bus.duty_r); end
        step(3);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        n_vec++; if (bus.busy !== 1'b0 || bus.dbg_state !== 2'd0 || bus.duty_r !== 16'd500 || bus.frame_idx !== 3'd0) begin
            n_err++; $display("FAIL stop_freeze: busy=%b state=%0d r=%0d idx=%0d expected 0 0 500 0", bus.busy, bus.dbg_state, bus.duty_r, bus.frame_idx); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (bus.frame_done) seen++;
        end
        n_vec++; if (seen != 0 || bus.duty_r !== 16'd500) begin
            n_err++; $display("FAIL stop_quiet: pulses=%0d r=%0d expected 0 500", seen, bus.duty_r); end
        pulse_start();
        step(1);
        step(4);
        n_vec++; if (bus.duty_r !== 16'd750) begin
            n_err++; $display("FAIL resume: duty_r=%0d expected 750", bus.duty_r); end
        wait_idle(100, p);
        n_vec++; if (p != 1 || bus.duty_r !== 16'd1000) begin
            n_err++; $display("FAIL resume_done: pulses=%0d r=%0d expected 1 1000", p, bus.duty_r); end
    endtask

    task automatic test_start_stop_same();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        n_vec++; if (bus.busy !== 1'b0 || bus.dbg_state !== 2'd0) begin
            n_err++; $display("FAIL start_stop_same: busy=%b state=%0d expected 0 0", bus.busy, bus.dbg_state); end
        step(2);
        n_vec++; if (bus.busy !== 1'b0) begin
            n_err++; $display("FAIL start_stop_after: busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_fast_tick_and_reset();
        int p;
        write_slot(0, 48'd0);
        config_run(0, 16'hFFFF, 0, 0, 1'b0);
        pulse_start();
        wait_idle(100, p);
        write_slot(0, {16'd3, 16'd0, 16'd0});
        config_run(0, 0, 0, 0, 1'b0);
        pulse_start();
        step(1);
        n_vec++; if (bus.duty_r !== 16'd0) begin
            n_err++; $display("FAIL fast_entry: r=%0d expected 0", bus.duty_r); end
        step(1);
        n_vec++; if (bus.duty_r !== 16'd1) begin
            n_err++; $display("FAIL fast_t1: r=%0d expected 1", bus.duty_r); end
        step(1);
        n_vec++; if (bus.duty_r !== 16'd2) begin
            n_err++; $display("FAIL fast_t2: r=%0d expected 2", bus.duty_r); end
        step(1);
        n_vec++; if (bus.duty_r !== 16'd3) begin
            n_err++; $display("FAIL fast_t3: r=%0d expected 3", bus.duty_r); end
        wait_idle(100, p);
        n_vec++; if (p != 1) begin
            n_err++; $display("FAIL fast_done: pulses=%0d expected 1", p); end
        write_slot(0, {16'h0040, 16'h0040, 16'h0040});
        config_run(0, 1, 0, 0, 1'b1);
        pulse_start();
        step(10);
        n_vec++; if (bus.busy !== 1'b1) begin
            n_err++; $display("FAIL prereset_busy: busy=%b expected 1", bus.busy); end
        #2;
        nRST = 1'b0;
        #1;
        n_vec++; if (bus.duty_r !== 16'd0 || bus.duty_g !== 16'd0 || bus.duty_b !== 16'd0 || bus.busy !== 1'b0 ||
                     bus.frame_idx !== 3'd0 || bus.frame_done !== 1'b0 || bus.dbg_state !== 2'd0) begin
            n_err++; $display("FAIL async_reset: %h/%h/%h busy=%b idx=%0d done=%b state=%0d expected all 0",
                              bus.duty_r, bus.duty_g, bus.duty_b, bus.busy, bus.frame_idx, bus.frame_done, bus.dbg_state); end
        #2;
        nRST = 1'b1;
        step(1);
        config_run(0, 16'hFFFF, 0, 0, 1'b0);
        pulse_start();
        step(2);
        n_vec++; if (bus.duty_r !== 16'd0 || bus.duty_g !== 16'd0) begin
            n_err++; $display("FAIL table_cleared: r=%h g=%h expected 0 0", bus.duty_r, bus.duty_g); end
        wait_idle(100, p);
    endtask

    // scenario sequence and final report
    initial begin
        n_vec = 0;
        n_err = 0;
        nRST = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        config_run(1, 1, 0, 0, 1'b0);
        test_reset();
        test_basic_fade();
        test_clamp();
        test_loop_live_edit();
        test_stop_mid_fade();
        test_start_stop_same();
        test_fast_tick_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
